// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } pipe_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_ctrl_if.sv
// Controller <-> datapath signal bundle. Counter outputs exist only when
// PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if
   import pipe_pkg::*;
`ifdef PIPE_CTRL_PERF_EN
   #(parameter int unsigned CNT_W = 32)
`endif
   ;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             ex_mem_to_reg;
   logic [REG_W-1:0] ex_rt;
   logic             ex_halt;
   logic             branch_taken;
   logic             jump;
   logic             mem_req;
   logic             mem_ready;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             halted;
   logic             mem_err;
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] memwait_cnt;
`endif

   // Datapath side: supplies pipeline status, consumes the controls.
   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_to_reg, ex_rt,
             ex_halt, branch_taken, jump, mem_req, mem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
             halted, mem_err
`ifdef PIPE_CTRL_PERF_EN
      , input stall_cnt, flush_cnt, memwait_cnt
`endif
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_to_reg, ex_rt,
             ex_halt, branch_taken, jump, mem_req, mem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
             halted, mem_err
`ifdef PIPE_CTRL_PERF_EN
      , output stall_cnt, flush_cnt, memwait_cnt
`endif
   );

endinterface : pipe_ctrl_if

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in ID/EX whose destination is
// read by the instruction in ID. Register 0 never matches.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_mem_to_reg,
   input  logic [REG_W-1:0] ex_rt,
   output logic             load_use_c
);

   assign load_use_c = ex_mem_to_reg && (ex_rt != REG_ZERO) &&
                       ((id_uses_rs && (id_rs == ex_rt)) ||
                        (id_uses_rt && (id_rt == ex_rt)));

endmodule : hazard_detect

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall/flush/enable decode, memory-wait
// timeout and halt drain. PIPE_CTRL_PERF_EN adds saturating event counters.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned MEM_TIMEOUT  = 255
`ifdef PIPE_CTRL_PERF_EN
   , parameter int unsigned CNT_W      = 32
`endif
) (
   input logic        clk,
   input logic        rst_b,
   pipe_ctrl_if.slave bus
);

   localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT) + 1;
   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES) + 1;
   localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   pipe_state_t        state, state_nxt;
   logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
   logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;
   logic               halted, mem_err, mem_err_nxt;
   logic               load_use_c, mem_stall_c, redirect_c;
   logic               pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic               if_id_flush, id_ex_flush;

   hazard_detect u_hazard (
      .id_rs         (bus.id_rs),
      .id_rt         (bus.id_rt),
      .id_uses_rs    (bus.id_uses_rs),
      .id_uses_rt    (bus.id_uses_rt),
      .ex_mem_to_reg (bus.ex_mem_to_reg),
      .ex_rt         (bus.ex_rt),
      .load_use_c    (load_use_c)
   );

   assign mem_stall_c = bus.mem_req && !bus.mem_ready;
   assign redirect_c  = bus.branch_taken || bus.jump;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= RUN;
         wait_cnt  <= '0;
         drain_cnt <= '0;
         halted    <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         drain_cnt <= drain_cnt_nxt;
         halted    <= (state_nxt == HALTED);
         mem_err   <= mem_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      drain_cnt_nxt = drain_cnt;
      mem_err_nxt   = 1'b0;
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      ex_mem_en     = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;

      unique case (state)
         RUN: begin
            if (mem_stall_c) begin
               {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = '0;
            end else if (redirect_c) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use_c) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end else if (bus.ex_halt) begin
               pc_en         = 1'b0;
               if_id_flush   = 1'b1;
               state_nxt     = DRAIN;
               drain_cnt_nxt = '0;
            end
         end
         // Wait counter holds completed wait cycles; leaving at WAIT_MAX keeps it saturated.
         MEM_WAIT: begin
            if (bus.mem_ready) begin
               state_nxt   = RUN;
               if_id_flush = redirect_c;
               id_ex_flush = redirect_c;
            end else if (wait_cnt == WAIT_MAX) begin
               mem_err_nxt = 1'b1;
               state_nxt   = RUN;
            end else begin
               {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         DRAIN: begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (mem_stall_c) begin
               ex_mem_en = 1'b0;
            end else if (drain_cnt == DRAIN_LAST) begin
               state_nxt = HALTED;
            end else begin
               drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
            end
         end
         HALTED: begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
         end
         default: state_nxt = RUN;
      endcase

      // While in reset every register captures and every stage is flushed.
      if (!rst_b) begin
         {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.if_id_en    = if_id_en;
   assign bus.id_ex_en    = id_ex_en;
   assign bus.ex_mem_en   = ex_mem_en;
   assign bus.if_id_flush = if_id_flush;
   assign bus.id_ex_flush = id_ex_flush;
   assign bus.halted      = halted;
   assign bus.mem_err     = mem_err;

`ifdef PIPE_CTRL_PERF_EN
   logic             stall_evt, flush_evt, memwait_evt;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;

   assign stall_evt   = (state == RUN) && !mem_stall_c && !redirect_c && load_use_c;
   assign flush_evt   = redirect_c && (((state == RUN) && !mem_stall_c) ||
                                       ((state == MEM_WAIT) && bus.mem_ready));
   assign memwait_evt = (state == MEM_WAIT);

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         memwait_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != '1))     stall_cnt   <= stall_cnt + CNT_W'(1);
         if (flush_evt && (flush_cnt != '1))     flush_cnt   <= flush_cnt + CNT_W'(1);
         if (memwait_evt && (memwait_cnt != '1)) memwait_cnt <= memwait_cnt + CNT_W'(1);
      end
   end

   assign bus.stall_cnt   = stall_cnt;
   assign bus.flush_cnt   = flush_cnt;
   assign bus.memwait_cnt = memwait_cnt;
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

   localparam int unsigned DC = 3;
   localparam int unsigned MT = 8;

   // Observed word: {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, halted, mem_err}
   localparam logic [7:0] W_RUN    = 8'b1111_00_00;
   localparam logic [7:0] W_RST    = 8'b1111_11_00;
   localparam logic [7:0] W_FLUSH  = 8'b1111_11_00;
   localparam logic [7:0] W_STALL  = 8'b0011_01_00;
   localparam logic [7:0] W_FREEZE = 8'b0000_00_00;
   localparam logic [7:0] W_HALT0  = 8'b0111_10_00;
   localparam logic [7:0] W_DRAIN  = 8'b0111_11_00;
   localparam logic [7:0] W_DRSTL  = 8'b0110_11_00;
   localparam logic [7:0] W_HALTED = 8'b0000_00_10;
   localparam logic [7:0] W_ERR    = 8'b1111_00_01;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       ld;
      logic [4:0] ert;
      logic       hlt;
      logic       br;
      logic       jmp;
      logic       mreq;
      logic       mrdy;
   } stim_t;

   typedef struct packed {
      stim_t      s;
      logic [7:0] exp;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pipe_ctrl_if bus ();

   pipe_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   // Behavioural model of the sequencer.
   bit m_wait, m_drain, m_stop, m_halted, m_err;
   int m_waited, m_drained;

   function automatic stim_t mk(input int rs, input int rt, input bit urs, input bit urt,
                                input bit ld, input int ert, input bit hlt, input bit br,
                                input bit jmp, input bit mreq, input bit mrdy);
      stim_t s;
      s.rs = 5'(rs); s.rt = 5'(rt); s.urs = urs; s.urt = urt; s.ld = ld;
      s.ert = 5'(ert); s.hlt = hlt; s.br = br; s.jmp = jmp; s.mreq = mreq; s.mrdy = mrdy;
      return s;
   endfunction

   function automatic logic [7:0] obs();
      return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
              bus.if_id_flush, bus.id_ex_flush, bus.halted, bus.mem_err};
   endfunction

   task automatic drive(input stim_t s);
      bus.id_rs = s.rs; bus.id_rt = s.rt; bus.id_uses_rs = s.urs; bus.id_uses_rt = s.urt;
      bus.ex_mem_to_reg = s.ld; bus.ex_rt = s.ert; bus.ex_halt = s.hlt;
      bus.branch_taken = s.br; bus.jump = s.jmp; bus.mem_req = s.mreq; bus.mem_ready = s.mrdy;
   endtask

   task automatic check(input string name, input logic [7:0] exp);
      logic [7:0] got;
      got = obs();
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b (pc,ifid,idex,exmem,iff,idf,halted,err)",
                  name, got, exp);
      end
   endtask

   // One clock: drive at the falling edge, compare shortly after.
   task automatic cyc(input stim_t s, input string name, input logic [7:0] exp);
      @(negedge clk);
      rst_b = 1'b1;
      drive(s);
      #1;
      check(name, exp);
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      rst_b = 1'b0;
      drive(mk(0,0,0,0,0,0,0,0,0,0,0));
      #1;
      check(name, W_RST);
      m_wait = 0; m_drain = 0; m_stop = 0; m_halted = 0; m_err = 0;
      m_waited = 0; m_drained = 0;
   endtask

   task automatic model_step(input stim_t s, output logic [7:0] exp);
      logic [5:0] e;
      bit stall, redirect, hazard, nerr;
      stall    = s.mreq && !s.mrdy;
      redirect = s.br || s.jmp;
      hazard   = s.ld && (s.ert != 0) &&
                 ((s.urs && s.rs == s.ert) || (s.urt && s.rt == s.ert));
      e = 6'b1111_00;
      nerr = 0;
      if (m_stop) begin
         e = 6'b0000_00;
      end else if (m_drain) begin
         e = {1'b0, 1'b1, 1'b1, !stall, 1'b1, 1'b1};
         if (!stall) begin
            m_drained++;
            if (m_drained == DC) begin m_drain = 0; m_stop = 1; end
         end
      end else if (m_wait) begin
         if (s.mrdy) begin
            m_wait = 0;
            if (redirect) e = 6'b1111_11;
         end else if (m_waited == MT) begin
            m_wait = 0;
            nerr = 1;
         end else begin
            e = 6'b0000_00;
            m_waited++;
         end
      end else begin
         if (stall) begin e = 6'b0000_00; m_wait = 1; m_waited = 0; end
         else if (redirect) e = 6'b1111_11;
         else if (hazard) e = 6'b0011_01;
         else if (s.hlt) begin e = 6'b0111_10; m_drain = 1; m_drained = 0; end
      end
      exp = {e, m_halted, m_err};
      m_halted = m_stop;
      m_err = nerr;
   endtask

   vec_t  tbl[12];
   stim_t idle, mw, s;
   logic [7:0] exp;

   initial begin
      idle = mk(0,0,0,0,0,0,0,0,0,0,0);
      mw   = mk(0,0,0,0,0,0,0,0,0,1,0);
      tbl[0]  = '{mk(0,0,0,0,0,0,0,0,0,0,0), W_RUN};
      tbl[1]  = '{mk(5,1,1,1,1,5,0,0,0,0,0), W_STALL};
      tbl[2]  = '{mk(0,0,1,1,1,0,0,0,0,0,0), W_RUN};
      tbl[3]  = '{mk(5,2,0,1,1,5,0,0,0,0,0), W_RUN};
      tbl[4]  = '{mk(3,7,0,1,1,7,0,0,0,0,0), W_STALL};
      tbl[5]  = '{mk(5,5,1,1,0,5,0,0,0,0,0), W_RUN};
      tbl[6]  = '{mk(0,0,0,0,0,0,0,1,0,0,0), W_FLUSH};
      tbl[7]  = '{mk(5,0,1,0,1,5,0,0,1,0,0), W_FLUSH};
      tbl[8]  = '{mk(5,0,1,0,1,5,1,1,0,1,0), W_FREEZE};
      tbl[9]  = '{mk(0,0,0,0,0,0,0,0,0,1,1), W_RUN};
      tbl[10] = '{mk(0,0,0,0,0,0,1,0,0,0,0), W_HALT0};
      tbl[11] = '{mk(9,0,1,0,1,9,1,0,0,0,0), W_STALL};

      foreach (tbl[i]) begin
         do_reset("reset");
         cyc(tbl[i].s, $sformatf("table[%0d]", i), tbl[i].exp);
      end

      // Load-use stall lasts one cycle; the bubble clears it.
      do_reset("reset");
      cyc(mk(5,0,1,0,1,5,0,0,0,0,0), "loaduse_stall", W_STALL);
      cyc(mk(5,0,1,0,0,5,0,0,0,0,0), "loaduse_after", W_RUN);

      // Memory busy for four cycles, released on the fifth.
      for (int i = 0; i < 4; i++) cyc(mw, $sformatf("memwait[%0d]", i), W_FREEZE);
      cyc(mk(0,0,0,0,0,0,0,0,0,1,1), "memwait_release", W_RUN);
      cyc(idle, "memwait_run", W_RUN);
      cyc(mw, "memwait_br0", W_FREEZE);
      cyc(mk(0,0,0,0,0,0,0,1,0,1,1), "memwait_br_release", W_FLUSH);

      // Timeout: RUN cycle plus MT wait cycles frozen, then abandon and pulse mem_err.
      for (int i = 0; i <= int'(MT); i++) cyc(mw, $sformatf("timeout_wait[%0d]", i), W_FREEZE);
      cyc(mw, "timeout_release", W_RUN);
      cyc(idle, "timeout_err", W_ERR);
      cyc(idle, "timeout_err_clear", W_RUN);

      // Halt drain and hold.
      do_reset("reset");
      cyc(mk(0,0,0,0,0,0,1,0,0,0,0), "halt_take", W_HALT0);
      for (int i = 0; i < int'(DC); i++) cyc(idle, $sformatf("drain[%0d]", i), W_DRAIN);
      cyc(idle, "halted_rise", W_HALTED);
      cyc(mk(0,0,0,0,0,0,0,1,0,0,0), "halted_hold", W_HALTED);

      // Memory stall during drain delays halted by one cycle.
      do_reset("reset");
      cyc(mk(0,0,0,0,0,0,1,0,0,0,0), "halt2_take", W_HALT0);
      cyc(idle, "drain2_a", W_DRAIN);
      cyc(mw, "drain2_stall", W_DRSTL);
      cyc(idle, "drain2_b", W_DRAIN);
      cyc(idle, "drain2_c", W_DRAIN);
      cyc(idle, "halted2_rise", W_HALTED);

      // Reset mid-drain and mid-wait returns to RUN.
      do_reset("reset");
      cyc(mk(0,0,0,0,0,0,1,0,0,0,0), "halt3_take", W_HALT0);
      cyc(idle, "drain3_a", W_DRAIN);
      do_reset("reset_mid_drain");
      cyc(idle, "after_drain_reset", W_RUN);
      cyc(mw, "wait3_a", W_FREEZE);
      cyc(mw, "wait3_b", W_FREEZE);
      do_reset("reset_mid_wait");
      cyc(idle, "after_wait_reset", W_RUN);

      // Randomized run against the model.
      do_reset("reset");
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset("rand_reset");
         end else begin
            s = mk($urandom_range(0,3), $urandom_range(0,3), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(0,3), $urandom_range(0,39) == 0,
                   $urandom_range(0,7) == 0, $urandom_range(0,7) == 0,
                   $urandom_range(0,2) == 0, $urandom_range(0,3) == 0);
            @(negedge clk);
            rst_b = 1'b1;
            drive(s);
            #1;
            model_step(s, exp);
            check($sformatf("rand[%0d]", n), exp);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_pipe_ctrl

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It decides each cycle whether the PC, IF/ID, ID/EX and EX/MEM pipeline registers capture, hold or load a bubble. It covers load-use hazards, taken branches and jumps, multi-cycle data-memory accesses and halt draining. It sits beside the decode stage and drives the enable/flush inputs of every pipeline register.

## Interface
- DRAIN_CYCLES, 3, cycles after a halt enters ID/EX before `halted` asserts (instruction retires through MEM/WB)
- MEM_TIMEOUT, 255, max MEM_WAIT cycles before `mem_err` pulses and the wait is abandoned
- CNT_W, 32, width of performance counters
- clk  in  1  clock, all state on rising edge
- rst_b  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source registers of instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads the register
- ex_mem_to_reg  in  1  ID/EX holds a load
- ex_rt  in  5  load destination held in ID/EX
- ex_halt  in  1  ID/EX holds a halt
- branch_taken  in  1  EX resolved a taken branch
- jump  in  1  EX holds a jump
- mem_req  in  1  EX/MEM holds a memory instruction this cycle
- mem_ready  in  1  data memory completes the access
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register capture enables
- if_id_flush, id_ex_flush  out  1 each  load bubble (all control zero)
- halted  out  1  core stopped, registered
- mem_err  out  1  one-cycle pulse on timeout, registered

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Load-use hazard (RUN only): `ex_mem_to_reg` and `ex_rt != 0` and ((`id_uses_rs` and `id_rs == ex_rt`) or (`id_uses_rt` and `id_rt == ex_rt`)).
- RUN priority, highest first:
  - `mem_req && !mem_ready`: all enables 0, no flush, go to MEM_WAIT and clear the wait counter.
  - `branch_taken || jump`: all enables 1, `if_id_flush` = `id_ex_flush` = 1.
  - Load-use hazard: `pc_en` = `if_id_en` = 0, `id_ex_flush` = 1, `ex_mem_en` = 1.
  - `ex_halt`: go to DRAIN with the drain counter at 0. `pc_en` = 0 and `if_id_flush` = 1 this cycle and every following cycle.
  - Otherwise all enables 1, no flush.
- MEM_WAIT:
  - All enables 0; the counter increments each cycle.
  - On `mem_ready`, all enables 1 this cycle and return to RUN. A branch or jump present in that same cycle also applies its flushes.
  - When the counter reaches MEM_TIMEOUT without `mem_ready`: pulse `mem_err`, enables 1, return to RUN.
- DRAIN:
  - `pc_en` = 0, `if_id_flush` = 1, `id_ex_flush` = 1, `ex_mem_en` = 1.
  - A memory stall still freezes `ex_mem_en` and pauses the drain counter.
  - When the counter reaches DRAIN_CYCLES-1, go to HALTED.
- HALTED: all enables 0, no flush, `halted` = 1. Only reset leaves this state.
- Arithmetic and width rules:
  - Counters are unsigned, sized $clog2 of their limit plus 1, and saturate (no wrap).
  - Register 0 never creates a hazard.

## Timing
- Enables and flushes are combinational (Mealy) from state and inputs in the same cycle. There must be no combinational path from `mem_ready` to `pc_en` except through the documented rules.
- `halted` and `mem_err` are registered.
- Load-use stall lasts exactly 1 cycle: the next cycle ID/EX holds the bubble, so the hazard clears by itself.
- Branch or jump penalty: 2 squashed instructions.
- Halt: `halted` rises DRAIN_CYCLES + 1 cycles after `ex_halt` is first sampled, plus any memory-stall cycles during the drain.
- Reset, asserted at any time including mid-wait or mid-drain:
  - state = RUN, counters = 0, `halted` = 0, `mem_err` = 0.
  - Enables read 1 and flushes read 1 while `rst_b` is low.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs `stall_cnt`, `flush_cnt` and `memwait_cnt` (CNT_W each).
  - They count, respectively: load-use stall cycles, branch/jump flush events, and MEM_WAIT cycles.
  - Reset to 0 and saturate.
- PIPE_CTRL_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `pipe_pkg`: `pipe_state_t` enum (RUN, MEM_WAIT, DRAIN, HALTED) and the `REG_ZERO` constant.
- One sub-module, `hazard_detect`: the combinational load-use comparator, reusable for a later forwarding unit.
- FSM, counters and output decode stay in `pipe_ctrl`.

## Test plan
- Load r5 in ID/EX; ID reads rs = 5 → one cycle with `pc_en` = 0, `id_ex_flush` = 1; next cycle all enables 1.
- Load to r0 with ID reading r0 → no stall.
- `branch_taken` = 1 in RUN → `if_id_flush` = `id_ex_flush` = 1, `pc_en` = 1 for one cycle.
- `mem_req` = 1, `mem_ready` low for 4 cycles → all enables 0 for 4 cycles; release on the fifth.
- With MEM_TIMEOUT = 8 and `mem_ready` stuck at 0 → `mem_err` pulses once, state returns to RUN.
- `ex_halt` = 1 with DRAIN_CYCLES = 3 → `halted` rises 4 cycles later and holds. `rst_b` pulsed low mid-drain → `halted` = 0 and state = RUN immediately.
